// File: rtl/spi_host.sv
`default_nettype none
// ============================================================================
// Module   : spi_host
// Brief    : SPI mode-0 byte host (MSB first) with software chip select.
// Revision : 1.0 - initial release
// ============================================================================
module spi_host #(
   parameter int CKDIV = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tx,
   input  logic [7:0] d,
   output logic [7:0] q,
   output logic       busy,
   output logic       done,
   input  logic       csWr,
   input  logic       csD,
   output logic       cs,
   output logic       ck,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   localparam logic [7:0] c_div_last = 8'(CKDIV - 1);

   state_t     r_state;
   logic [6:0] r_tx_sh;   // bit 7 goes straight to mosi at load time
   logic [7:0] r_rx_sh;
   logic [2:0] r_bit;
   logic [7:0] r_div;
   logic       w_div_end;

   assign w_div_end = (r_div == c_div_last);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_tx_sh <= 7'd0;
         r_rx_sh <= 8'd0;
         r_bit   <= 3'd0;
         r_div   <= 8'd0;
         q       <= 8'h00;
         busy    <= 1'b0;
         done    <= 1'b0;
         cs      <= 1'b1;
         ck      <= 1'b0;
         mosi    <= 1'b1;
      end else begin
         done <= 1'b0;
         if (csWr) begin
            cs <= csD;
         end
         case (r_state)
            IDLE: begin
               ck   <= 1'b0;
               mosi <= 1'b1;
               busy <= 1'b0;
               // a strobe coinciding with the done pulse belongs to the old transfer
               if (tx && !done) begin
                  r_tx_sh <= d[6:0];
                  mosi    <= d[7];
                  r_bit   <= 3'd0;
                  r_div   <= 8'd0;
                  busy    <= 1'b1;
                  r_state <= LOW;
               end
            end
            LOW: begin
               if (w_div_end) begin
                  ck      <= 1'b1;
                  r_rx_sh <= {r_rx_sh[6:0], miso};
                  r_div   <= 8'd0;
                  r_state <= HIGH;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            HIGH: begin
               if (w_div_end) begin
                  ck    <= 1'b0;
                  r_div <= 8'd0;
                  if (r_bit != 3'd7) begin
                     r_bit   <= r_bit + 3'd1;
                     mosi    <= r_tx_sh[6];
                     r_tx_sh <= {r_tx_sh[5:0], 1'b0};
                     r_state <= LOW;
                  end else begin
                     mosi    <= 1'b1;
                     q       <= r_rx_sh;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= IDLE;
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/spi_host.md
SPI_HOST -- requirements
Module: spi_host

Interface
REQ-001 SHALL have parameter CKDIV, default 2, meaning system-clock cycles per SPI half-period; legal range 1..255.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tx  input  1  one-cycle strobe starting an 8-bit transfer of d.
REQ-005 SHALL have port d  input  8  byte to transmit, sampled on the cycle tx is accepted.
REQ-006 SHALL have port q  output  8  last received byte.
REQ-007 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when q is updated.
REQ-009 SHALL have port csWr  input  1  one-cycle strobe loading chip-select from csD.
REQ-010 SHALL have port csD  input  1  chip-select value, 0 = card selected.
REQ-011 SHALL have port cs  output  1  SPI chip select to the SD card, active-low.
REQ-012 SHALL have port ck  output  1  SPI clock.
REQ-013 SHALL have port mosi  output  1  serial data to card.
REQ-014 SHALL have port miso  input  1  serial data from card.

Function
REQ-015 SHALL implement SPI mode 0, MSB first: ck idles low, miso sampled at ck rising, mosi changes at ck falling.
REQ-016 SHALL use states IDLE, LOW, HIGH; every output is registered.
REQ-017 IDLE: ck=0, mosi=1, busy=0; tx=1 SHALL load tx shift register with d, set mosi=d[7], bit counter=0, divider=0, busy=1 from the next cycle, and enter LOW.
REQ-018 LOW: after CKDIV cycles SHALL set ck=1, shift rx register left taking miso into bit 0, reset divider, and enter HIGH.
REQ-019 HIGH: after CKDIV cycles SHALL set ck=0; if bit counter <7, SHALL increment it, drive mosi with the next tx bit, and enter LOW.
REQ-020 HIGH with bit counter =7: SHALL set ck=0, mosi=1, q=rx register, done=1 for exactly one cycle, busy=0, and enter IDLE.
REQ-021 Transfer length SHALL be 16*CKDIV cycles from the first busy cycle to done, inclusive of the done cycle as the last busy-low transition.
REQ-022 tx asserted while busy=1 SHALL be ignored, with no effect on d capture, q, or timing.
REQ-023 tx on the same cycle done is asserted SHALL be ignored; a new transfer may start on the cycle after done.
REQ-024 csWr SHALL be accepted in any state; cs SHALL equal csD on the cycle after csWr; a cs change mid-transfer SHALL NOT alter transfer timing.
REQ-025 Simultaneous tx and csWr in IDLE SHALL both take effect: cs updates and the transfer starts on the same following cycle.
REQ-026 The divider SHALL count 0..CKDIV-1 and wrap; CKDIV=1 SHALL toggle ck every cycle.
REQ-027 q SHALL hold its value between transfers; done SHALL never be high in two consecutive cycles.

Reset
REQ-028 reset=1 SHALL force, asynchronously: state=IDLE, cs=1, ck=0, mosi=1, q=8'h00, busy=0, done=0, counters and shift registers = 0.
REQ-029 reset asserted mid-transfer SHALL abort the transfer without a done pulse; q SHALL read 8'h00 afterwards.
REQ-030 After reset release, the first tx SHALL be accepted on the first clock edge with reset low.

Verification
REQ-031 CKDIV=2, miso looped from mosi, tx with d=8'hA5 -> busy high 32 cycles, 8 rising ck edges, done one cycle, q=8'hA5.
REQ-032 miso tied 1, d=8'h00 -> mosi low on all 8 bits, q=8'hFF; miso tied 0, d=8'hFF -> q=8'h00.
REQ-033 Second tx 5 cycles into a transfer with d=8'h3C -> ignored; q equals the first byte's result; only one done pulse.
REQ-034 csWr with csD=0 in IDLE -> cs=0 next cycle; csWr with csD=1 mid-transfer -> cs=1 next cycle, ck/mosi sequence unchanged.
REQ-035 Reset pulse at cycle 10 of a transfer -> cs=1, ck=0, mosi=1, busy=0 immediately; no done; q=8'h00.
REQ-036 CKDIV=1, two back-to-back transfers (tx on cycle after done) -> each 16 cycles, ck period 2 cycles, both q values correct.
